fetch_stage: RTL and testbench

Instruction-fetch stage of the 16-bit pipelined processor, sitting directly upstream of the IF/ID pipeline register. Holds the PC, issues requests to the instruction memory over a ready/valid interface, and buffers returned instructions in a 2-entry queue. Presents `{instr, next_pc}` to IF/ID under a valid/ready handshake and handles redirects from branch/jump resolution and HALT detection. Substitutes the NOP encoding 16'h0800 whenever no valid instruction is presented.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_buffer.sv | 49 ++++
 rtl/fetch_stage.sv | 121 ++++++++++++
 tb/tb_fetch_stage.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package fetch_pkg;

  localparam logic [15:0] NOP_INSTR   = 16'h0800;
  localparam logic [4:0]  HALT_OPCODE = 5'b00000;
  localparam logic [15:0] PC_INC      = 16'd2;
  localparam int unsigned ENTRY_W     = 32;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetchState_t;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] nextPc;
  } fetchEntry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO holding fetched {instr, nextPc} pairs ahead of IF/ID.
module fetch_buffer
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rstN,
  input  logic               push,
  input  logic [ENTRY_W-1:0] pushData,
  input  logic               pop,
  input  logic               flush,
  output logic [ENTRY_W-1:0] headData,
  output logic [1:0]         count
);

  logic [ENTRY_W-1:0] mem [2];
  logic               wrPtr;
  logic               rdPtr;
  logic               doPush;
  logic               doPop;

  assign doPop    = pop && (count != 2'd0);
  // A push into a full buffer is only taken when the head leaves in the same cycle.
  assign doPush   = push && ((count != 2'd2) || doPop);
  assign headData = mem[rdPtr];

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wrPtr  <= 1'b0;
      rdPtr  <= 1'b0;
      count  <= '0;
    end else if (flush) begin
      wrPtr  <= 1'b0;
      rdPtr  <= 1'b0;
      count  <= '0;
    end else begin
      if (doPush) begin
        mem[wrPtr] <= pushData;
        wrPtr      <= !wrPtr;
      end
      if (doPop) begin
        rdPtr <= !rdPtr;
      end
      count <= count + 2'(doPush) - 2'(doPop);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, credit-limited imem requests, 2-entry return
// buffer, redirect/squash handling and HALT detection.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [15:0] imem_rdata,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_instr,
  output logic [15:0] out_next_pc,
  output logic        halted
);

  fetchState_t state;
  fetchState_t stateNext;
  fetchEntry_t head;
  logic [15:0] pc;
  logic [15:0] respNextPc;
  logic        outstanding;
  logic        squash;
  logic [1:0]  bufCount;
  logic        pop;
  logic        respValid;
  logic        respKeep;
  logic        respHalt;
  logic        push;
  logic        accept;
  logic        creditOk;

  assign out_valid   = (bufCount != 2'd0);
  assign pop         = out_valid && out_ready;
  assign respValid   = imem_rvalid && outstanding;
  assign respKeep    = respValid && !squash;
  assign respHalt    = respKeep && (imem_rdata[15:11] == HALT_OPCODE);
  assign push        = respKeep && !redirect;
  assign accept      = imem_req && imem_ready;
  assign creditOk    = (3'(bufCount) + 3'(outstanding) - 3'(pop)) < 3'd2;
  assign imem_addr   = pc;
  assign out_instr   = out_valid ? head.instr : NOP_INSTR;
  assign out_next_pc = head.nextPc;

  fetch_buffer uBuffer (
    .clk      (clk),
    .rstN     (rst),
    .push     (push),
    .pushData ({imem_rdata, respNextPc}),
    .pop      (pop),
    .flush    (redirect),
    .headData (head),
    .count    (bufCount)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    if (redirect) begin
      stateNext = RUN;
    end else if (respHalt) begin
      stateNext = HALTED;
    end
  end

  // A new request may go out in the cycle the previous response returns.
  always_comb begin
    halted   = (state == HALTED);
    imem_req = 1'b0;
    if (rst && (state == RUN) && !redirect && !respHalt &&
        (!outstanding || respValid) && creditOk) begin
      imem_req = 1'b1;
    end
  end

  // Redirect blocks issue, so only an already-outstanding request needs squashing;
  // a response arriving in the redirect cycle itself is simply not pushed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= RESET_PC;
      respNextPc  <= '0;
      outstanding <= 1'b0;
      squash      <= 1'b0;
    end else begin
      if (redirect) begin
        pc <= redirect_pc;
      end else if (accept) begin
        pc <= pc + PC_INC;
      end

      if (accept) begin
        outstanding <= 1'b1;
        respNextPc  <= pc + PC_INC;
      end else if (respValid) begin
        outstanding <= 1'b0;
      end

      if (redirect) begin
        squash <= outstanding && !imem_rvalid;
      end else if (respValid) begin
        squash <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a single-slot instruction-memory model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [15:0] out_next_pc;
  logic        halted;

  int unsigned nAsserts = 0;
  int unsigned nFails   = 0;
  int unsigned cyc      = 0;

  logic        memPend;
  logic [15:0] memAddr;
  int unsigned memDue;
  int unsigned memLat;
  logic        haltEn;
  logic [15:0] haltAddr;
  logic [15:0] expNext;

  logic        obsReq;
  logic        obsValid;
  logic        obsHalted;
  logic [15:0] obsAddr;
  logic [15:0] obsInstr;
  logic [15:0] obsNpc;

  fetch_stage #(
    .RESET_PC  (16'h0000),
    .NOP_INSTR (16'h0800)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_next_pc (out_next_pc),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] memData(input logic [15:0] a);
    return (haltEn && (a == haltAddr)) ? 16'h0000 : (16'h8000 | a);
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, sample 1ns later, then update the memory model.
  task automatic step(input logic rdy, input logic oRdy, input logic redir, input logic [15:0] rpc);
    @(negedge clk);
    imem_ready  = rdy;
    out_ready   = oRdy;
    redirect    = redir;
    redirect_pc = rpc;
    imem_rvalid = memPend && (cyc == memDue);
    imem_rdata  = imem_rvalid ? memData(memAddr) : 16'hDEAD;
    #1;
    obsReq    = imem_req;
    obsAddr   = imem_addr;
    obsValid  = out_valid;
    obsInstr  = out_instr;
    obsNpc    = out_next_pc;
    obsHalted = halted;
    if (out_valid && out_ready) begin
      check("popNextPc", out_next_pc, expNext);
      check("popInstr", out_instr, memData(expNext - 16'd2));
      expNext = expNext + 16'd2;
    end
    if (imem_rvalid) memPend = 1'b0;
    if (imem_req && imem_ready) begin
      memPend = 1'b1;
      memAddr = imem_addr;
      memDue  = cyc + memLat;
    end
    cyc++;
  endtask

  initial begin
    rst = 1'b0; imem_ready = 1'b1; out_ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
    imem_rvalid = 1'b0; imem_rdata = '0;
    memPend = 1'b0; memAddr = '0; memDue = 0; memLat = 1;
    haltEn = 1'b0; haltAddr = 16'h0006; expNext = 16'h0002;
    #1;
    check("rstReq", 16'(imem_req), 16'h0000);
    check("rstAddr", imem_addr, 16'h0000);
    check("rstValid", 16'(out_valid), 16'h0000);
    check("rstInstr", out_instr, 16'h0800);
    check("rstNpc", out_next_pc, 16'h0000);
    check("rstHalted", 16'(halted), 16'h0000);
    @(posedge clk); #1; rst = 1'b1;

    // Streaming with a 1-cycle memory
    step(1, 1, 0, 0); check("s0Req", 16'(obsReq), 16'h1); check("s0Addr", obsAddr, 16'h0000);
    check("s0Valid", 16'(obsValid), 16'h0);
    step(1, 1, 0, 0); check("s1Addr", obsAddr, 16'h0002); check("s1Valid", 16'(obsValid), 16'h0);
    step(1, 1, 0, 0); check("s2Valid", 16'(obsValid), 16'h1); check("s2Npc", obsNpc, 16'h0002);
    check("s2Instr", obsInstr, 16'h8000); check("s2Addr", obsAddr, 16'h0004);
    step(1, 1, 0, 0); check("s3Npc", obsNpc, 16'h0004);
    step(1, 1, 0, 0); check("s4Npc", obsNpc, 16'h0006); check("s4Addr", obsAddr, 16'h0008);

    // Downstream stall for 5 cycles
    step(1, 0, 0, 0); check("st0Req", 16'(obsReq), 16'h0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
    check("st4Req", 16'(obsReq), 16'h0); check("st4Valid", 16'(obsValid), 16'h1);
    check("st4Npc", obsNpc, 16'h0008); check("st4Instr", obsInstr, 16'h8006);
    check("st4Addr", obsAddr, 16'h000A);
    step(1, 1, 0, 0); check("relReq", 16'(obsReq), 16'h1); check("relAddr", obsAddr, 16'h000A);
    step(1, 1, 0, 0);
    memLat = 2;
    step(1, 1, 0, 0); check("preRdNpc", obsNpc, 16'h000C); check("preRdAddr", obsAddr, 16'h000E);

    // Redirect with a request outstanding
    step(1, 1, 1, 16'h0040); check("rdReq", 16'(obsReq), 16'h0);
    expNext = 16'h0042; memLat = 1;
    step(1, 1, 0, 0); check("rd1Valid", 16'(obsValid), 16'h0); check("rd1Instr", obsInstr, 16'h0800);
    check("rd1Req", 16'(obsReq), 16'h1); check("rd1Addr", obsAddr, 16'h0040);
    step(1, 1, 0, 0); check("rd2Valid", 16'(obsValid), 16'h0); check("rd2Addr", obsAddr, 16'h0042);
    step(1, 1, 0, 0); check("rd3Npc", obsNpc, 16'h0042); check("rd3Instr", obsInstr, 16'h8040);

    // Fill the buffer, then reset mid-transaction
    step(1, 0, 0, 0);
    step(1, 0, 0, 0); check("fullReq", 16'(obsReq), 16'h0); check("fullValid", 16'(obsValid), 16'h1);
    check("fullNpc", obsNpc, 16'h0044);
    @(negedge clk); rst = 1'b0; memPend = 1'b0;
    #1;
    check("midRstReq", 16'(imem_req), 16'h0000);
    check("midRstAddr", imem_addr, 16'h0000);
    check("midRstValid", 16'(out_valid), 16'h0000);
    check("midRstInstr", out_instr, 16'h0800);
    check("midRstNpc", out_next_pc, 16'h0000);
    check("midRstHalted", 16'(halted), 16'h0000);
    @(posedge clk); #1;
    rst = 1'b1; haltEn = 1'b1; expNext = 16'h0002;
    memPend = 1'b1; memAddr = 16'h0100; memDue = cyc;   // stray response right after release

    // HALT returned at address 6
    step(1, 1, 0, 0); check("h0Req", 16'(obsReq), 16'h1); check("h0Addr", obsAddr, 16'h0000);
    step(1, 1, 0, 0); check("h1Valid", 16'(obsValid), 16'h0); check("h1Addr", obsAddr, 16'h0002);
    step(1, 1, 0, 0); check("h2Npc", obsNpc, 16'h0002);
    step(1, 1, 0, 0); check("h3Addr", obsAddr, 16'h0006);
    step(1, 1, 0, 0); check("h4Req", 16'(obsReq), 16'h0); check("h4Npc", obsNpc, 16'h0006);
    step(1, 1, 0, 0); check("h5Halted", 16'(obsHalted), 16'h1); check("h5Npc", obsNpc, 16'h0008);
    check("h5Instr", obsInstr, 16'h0000); check("h5Req", 16'(obsReq), 16'h0);
    step(1, 1, 0, 0); check("h6Valid", 16'(obsValid), 16'h0); check("h6Req", 16'(obsReq), 16'h0);
    check("h6Halted", 16'(obsHalted), 16'h1);
    step(1, 1, 1, 16'h0010); check("h7Req", 16'(obsReq), 16'h0);
    expNext = 16'h0012; memLat = 3; haltEn = 1'b0;
    step(1, 1, 0, 0); check("h8Req", 16'(obsReq), 16'h1); check("h8Addr", obsAddr, 16'h0010);
    check("h8Halted", 16'(obsHalted), 16'h0);

    // imem_ready stalls with varying latency
    step(1, 1, 0, 0); check("w0Req", 16'(obsReq), 16'h0); check("w0Addr", obsAddr, 16'h0012);
    step(1, 1, 0, 0);
    step(0, 1, 0, 0); check("w2Req", 16'(obsReq), 16'h1); check("w2Addr", obsAddr, 16'h0012);
    step(0, 1, 0, 0); check("w3Addr", obsAddr, 16'h0012); check("w3Valid", 16'(obsValid), 16'h1);
    step(0, 1, 0, 0); check("w4Addr", obsAddr, 16'h0012); check("w4Valid", 16'(obsValid), 16'h0);
    memLat = 1;
    step(1, 1, 0, 0); check("w5Addr", obsAddr, 16'h0012);
    memLat = 2;
    step(1, 1, 0, 0); check("w6Addr", obsAddr, 16'h0014);
    memLat = 1;
    step(1, 1, 0, 0); check("w7Npc", obsNpc, 16'h0014); check("w7Req", 16'(obsReq), 16'h0);
    step(1, 1, 0, 0); check("w8Addr", obsAddr, 16'h0016);
    step(1, 1, 0, 0); check("w9Npc", obsNpc, 16'h0016);
    step(1, 1, 0, 0);

    // PC wrap at the top of the address space
    step(1, 1, 1, 16'hFFFE); check("wrRdReq", 16'(obsReq), 16'h0);
    expNext = 16'h0000;
    step(1, 1, 0, 0); check("wr0Addr", obsAddr, 16'hFFFE); check("wr0Valid", 16'(obsValid), 16'h0);
    step(1, 1, 0, 0); check("wr1Addr", obsAddr, 16'h0000);
    step(1, 1, 0, 0); check("wr2Npc", obsNpc, 16'h0000); check("wr2Instr", obsInstr, 16'hFFFE);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
